// File: rtl/servo_pwm_posicao_if.sv
// Position/PWM bundle between the position sequencer and the servo PWM block.
// The liga enable exists only when SERVO_LIGA_EN is defined.
interface servo_pwm_posicao_if;
  logic [2:0] posicao;
  logic       pwm;
  logic       fim_periodo;
  logic [2:0] db_posicao;
`ifdef SERVO_LIGA_EN
  logic       liga;
`endif

  // Sequencer side: drives the requested position, sees the waveform and period tick.
  modport master (
`ifdef SERVO_LIGA_EN
    output liga,
`endif
    output posicao,
    input  pwm,
    input  fim_periodo,
    input  db_posicao
  );

  modport slave (
`ifdef SERVO_LIGA_EN
    input  liga,
`endif
    input  posicao,
    output pwm,
    output fim_periodo,
    output db_posicao
  );
endinterface

// File: rtl/servo_pwm_posicao.sv
// Servo PWM generator: pulse width linear in the position sampled once per period.
// Optional output enable `liga` is built in when SERVO_LIGA_EN is defined.
module servo_pwm_posicao #(
  parameter int PERIODO     = 1000000,
  parameter int LARGURA_MIN = 50000,
  parameter int PASSO       = 7143
) (
  input  logic                 clock,
  input  logic                 zera_as_n,
  servo_pwm_posicao_if.slave   bus
);

  localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  // One extra bit so min + 7*step can exceed the period without wrapping.
  localparam int LW = CW + 1;
  localparam logic [CW-1:0] C_ULTIMO = CW'(PERIODO - 1);
  localparam logic [LW-1:0] L_RESET  = LW'(LARGURA_MIN);
  localparam logic [LW-1:0] L_PASSO  = LW'(PASSO);

  logic [CW-1:0] c_q,     c_d;
  logic [2:0]    pos_q,   pos_d;
  logic [LW-1:0] l_q,     l_d;
  logic          pwm_q,   pwm_d;
  logic          fim_q,   fim_d;
  logic          amostra;
  logic          habilita;
  logic [LW-1:0] l_novo;

`ifdef SERVO_LIGA_EN
  logic liga_q, liga_d;
`endif

  // NOTE: every output of a combinational block gets a value on every path; defaults first avoids latches.
  always_comb begin
    amostra = (c_q == C_ULTIMO);
    l_novo  = L_RESET + LW'(bus.posicao) * L_PASSO;

    c_d     = c_q + 1'b1;
    pos_d   = pos_q;
    l_d     = l_q;
    if (amostra) begin
      c_d   = '0;
      pos_d = bus.posicao;
      l_d   = l_novo;
    end

`ifdef SERVO_LIGA_EN
    liga_d   = amostra ? bus.liga : liga_q;
    habilita = liga_q;
`else
    habilita = 1'b1;
`endif

    // Saturation falls out naturally: with l_q >= PERIODO the compare is always true.
    pwm_d = habilita && ({1'b0, c_q} < l_q);
    fim_d = amostra;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      c_q    <= '0;
      pos_q  <= '0;
      l_q    <= L_RESET;
      pwm_q  <= 1'b0;
      fim_q  <= 1'b0;
`ifdef SERVO_LIGA_EN
      liga_q <= 1'b0;
`endif
    end else begin
      c_q    <= c_d;
      pos_q  <= pos_d;
      l_q    <= l_d;
      pwm_q  <= pwm_d;
      fim_q  <= fim_d;
`ifdef SERVO_LIGA_EN
      liga_q <= liga_d;
`endif
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.fim_periodo = fim_q;
  assign bus.db_posicao  = pos_q;

endmodule

// File: tb/tb_servo_pwm_posicao.sv
// Randomized self-checking bench for servo_pwm_posicao against a period-level reference model.
// A second instance with LARGURA_MIN=18 exercises saturation alongside the main one.
module tb_servo_pwm_posicao;

  localparam int P      = 20;
  localparam int LMIN   = 2;
  localparam int LMIN_S = 18;
  localparam int STEP   = 2;

  logic clk = 1'b0;
  logic zera_as_n = 1'b0;

  servo_pwm_posicao_if bus_if ();
  servo_pwm_posicao_if bus_sat ();

  servo_pwm_posicao #(.PERIODO(P), .LARGURA_MIN(LMIN), .PASSO(STEP)) dut (
    .clock     (clk),
    .zera_as_n (zera_as_n),
    .bus       (bus_if)
  );

  servo_pwm_posicao #(.PERIODO(P), .LARGURA_MIN(LMIN_S), .PASSO(STEP)) dut_sat (
    .clock     (clk),
    .zera_as_n (zera_as_n),
    .bus       (bus_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed per period rather than per flop.
  int         n;        // rising edges since reset release
  int         w, w_s;   // expected high width of the current period
  bit         en, en_s; // output enabled for the current period
  int         hi, hi_s; // observed high cycles so far in the current period
  logic [2:0] db_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int largura(input int lmin, input int pos);
    int v;
    v = lmin + pos * STEP;
    return (v >= P) ? P : v;
  endfunction

  task automatic reset_model();
    n      = 0;
    w      = LMIN;
    w_s    = LMIN_S;
    hi     = 0;
    hi_s   = 0;
    db_exp = 3'd0;
`ifdef SERVO_LIGA_EN
    en     = 1'b0;
    en_s   = 1'b0;
`else
    en     = 1'b1;
    en_s   = 1'b1;
`endif
  endtask

  task automatic check_zeros(input string tag);
    check({tag, "_pwm"},     bus_if.pwm,          0);
    check({tag, "_fim"},     bus_if.fim_periodo,  0);
    check({tag, "_db"},      bus_if.db_posicao,   0);
    check({tag, "_pwm_sat"}, bus_sat.pwm,         0);
    check({tag, "_fim_sat"}, bus_sat.fim_periodo, 0);
  endtask

  // Drive one cycle of inputs, advance one edge, compare against the model.
  task automatic step(input logic [2:0] p, input logic l);
    int phase;
    bus_if.posicao = p;
`ifdef SERVO_LIGA_EN
    bus_if.liga = l;
`endif
    @(posedge clk);
    #1;
    n++;
    phase = (n - 1) % P;
    check("pwm",     bus_if.pwm,          (en   && phase < w));
    check("pwm_sat", bus_sat.pwm,         (en_s && phase < w_s));
    check("fim",     bus_if.fim_periodo,  (phase == P - 1));
    check("fim_sat", bus_sat.fim_periodo, (phase == P - 1));
    hi   += int'(bus_if.pwm);
    hi_s += int'(bus_sat.pwm);
    if (phase == P - 1) begin
      check("largura",     hi,   en   ? w   : 0);
      check("largura_sat", hi_s, en_s ? w_s : 0);
      hi     = 0;
      hi_s   = 0;
      w      = largura(LMIN, int'(p));
      w_s    = largura(LMIN_S, 7);
      db_exp = p;
`ifdef SERVO_LIGA_EN
      en     = l;
      en_s   = 1'b1;
`endif
    end
    check("db", bus_if.db_posicao, db_exp);
  endtask

  initial begin
    int k;
    logic [2:0] p_rnd;
    logic       l_rnd;

    bus_if.posicao  = 3'd5;
    bus_sat.posicao = 3'd7;
`ifdef SERVO_LIGA_EN
    bus_if.liga  = 1'b1;
    bus_sat.liga = 1'b1;
`endif

    // Reset state, held across clock edges.
    #12;
    check_zeros("reset");
    @(negedge clk);
    zera_as_n = 1'b1;
    reset_model();

    // Position 5 held: first period uses position 0, then width 12.
    for (int i = 0; i < 3 * P; i++) step(3'd5, 1'b1);

    // Sweep 0..7, one period each; any 20-cycle block holds exactly one sample edge.
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < P; i++) step(3'(p), 1'b1);
    for (int i = 0; i < P; i++) step(3'd7, 1'b1);

    // 7 -> 0 while C == 5 inside a 16-cycle pulse.
    k = 0;
    while (!(w == 16 && n % P == 5) && k < 3 * P) begin
      step(3'd7, 1'b1);
      k++;
    end
    check("espera_c5", (k < 3 * P), 1);
    for (int i = 0; i < 2 * P + 5; i++) step(3'd0, 1'b1);

    // Asynchronous reset while C == 3 of a 16-cycle pulse.
    k = 0;
    while (!(w == 16 && n % P == 3) && k < 4 * P) begin
      step(3'd7, 1'b1);
      k++;
    end
    check("espera_c3", (k < 4 * P), 1);
    check("pwm_antes_reset", bus_if.pwm, 1);
    #2;
    zera_as_n = 1'b0;
    #1;
    check_zeros("reset_async");
    @(posedge clk);
    #1;
    check_zeros("reset_mantido");
    @(negedge clk);
    zera_as_n = 1'b1;
    reset_model();
    for (int i = 0; i < 2 * P; i++) step(3'd7, 1'b1);

`ifdef SERVO_LIGA_EN
    // Disable for one sample edge, then re-enable.
    for (int i = 0; i < P; i++) step(3'd3, 1'b0);
    for (int i = 0; i < 2 * P; i++) step(3'd3, 1'b1);
`endif

    // Random position changes at arbitrary cycles.
    p_rnd = 3'($urandom_range(0, 7));
    l_rnd = 1'b1;
    for (int i = 0; i < 15 * P; i++) begin
      if ($urandom_range(0, 7) == 0) p_rnd = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) l_rnd = ~l_rnd;
      step(p_rnd, l_rnd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
